data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder on the far side of the CPU MEM-stage interface.
- Accepts MemRd_i / MemWr_i requests with address and write data, and serves them after a configurable latency.
- Back-pressures the pipeline through stall_o and signals completion through a one-cycle ack_o.
- Replaces the single-cycle data memory where memory latency must be modelled.

---
 rtl/data_mem_responder.sv | 96 +++++++++
 tb/tb_data_mem_responder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory; MemRd_i/MemWr_i in, RdData_o/ack_o/stall_o/align_err_o and saturating op counters out
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] WrData_i,
  input  logic        MemWr_i,
  input  logic        MemRd_i,
  output logic [31:0] RdData_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        align_err_o,
  output logic [15:0] rd_count_o,
  output logic [15:0] wr_count_o
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic mis_q, mis_d, wr_q, wr_d, ack_q, ack_d, aerr_q, aerr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [15:0] rdc_q, rdc_d, wrc_q, wrc_d;
  logic [31:0] mem_q [DEPTH];
  logic req, go_resp;
  logic unused_addr;
  assign unused_addr = ^addr_i[31:IW+2];
  assign req = MemRd_i | MemWr_i;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdc_d   = rdc_q;
    wrc_d   = wrc_q;
    go_resp = 1'b0;
    if (state_q == IDLE && req) begin
      idx_d   = addr_i[IW+1:2];
      mis_d   = |addr_i[1:0];
      wr_d    = MemWr_i;
      wdata_d = WrData_i;
      cnt_d   = 4'(LATENCY - 1);
      state_d = LATENCY > 1 ? WAIT : RESP;
      go_resp = LATENCY == 1;
    end else if (state_q == WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      go_resp = cnt_q == 4'd1;
      state_d = go_resp ? RESP : WAIT;
    end else if (state_q == RESP) begin
      state_d = IDLE;
      rdc_d   = (!wr_q && rdc_q != 16'hFFFF) ? rdc_q + 16'd1 : rdc_q;
      wrc_d   = (wr_q && wrc_q != 16'hFFFF) ? wrc_q + 16'd1 : wrc_q;
    end
    // the _d copies of the request are valid both for a fresh IDLE request and a latched one
    rdata_d = (go_resp && !wr_d) ? (mis_d ? 32'd0 : mem_q[idx_d]) : rdata_q;
    ack_d   = go_resp;
    aerr_d  = go_resp && mis_d;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      aerr_q  <= 1'b0;
      rdc_q   <= '0;
      wrc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      aerr_q  <= aerr_d;
      rdc_q   <= rdc_d;
      wrc_q   <= wrc_d;
    end
  end
  always_ff @(posedge clk_i) begin
    idx_q   <= idx_d;
    mis_q   <= mis_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
    if (!rst_i && state_q == RESP && wr_q && !mis_q) mem_q[idx_q] <= wdata_q;
  end
  assign stall_o     = !rst_i && ((state_q == IDLE && req) || state_q == WAIT);
  assign RdData_o    = rdata_q;
  assign ack_o       = ack_q;
  assign align_err_o = aerr_q;
  assign rd_count_o  = rdc_q;
  assign wr_count_o  = wrc_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of data_mem_responder against an array model
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int LAT = 3;
  logic clk_i = 1'b0;
  logic rst_i, MemWr_i, MemRd_i, ack_o, stall_o, align_err_o;
  logic [31:0] addr_i, WrData_i, RdData_o;
  logic [15:0] rd_count_o, wr_count_o;
  int checks = 0, errors = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_rd = 32'd0;
  int rdc = 0, wrc = 0;
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .WrData_i(WrData_i),
    .MemWr_i(MemWr_i), .MemRd_i(MemRd_i), .RdData_o(RdData_o), .ack_o(ack_o),
    .stall_o(stall_o), .align_err_o(align_err_o), .rd_count_o(rd_count_o),
    .wr_count_o(wr_count_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic hold);
    int n, stalls;
    logic mis;
    mis = |a[1:0];
    stalls = 0;
    MemRd_i = rd;
    MemWr_i = wr;
    addr_i = a;
    WrData_i = d;
    if (wr) begin
      if (!mis) mem_m[a[9:2]] = d;
      wrc = wrc < 65535 ? wrc + 1 : wrc;
    end else begin
      exp_rd = mis ? 32'd0 : mem_m[a[9:2]];
      rdc = rdc < 65535 ? rdc + 1 : rdc;
    end
    for (n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (stall_o) stalls++;
      if (ack_o) break;
      if (!hold && n >= 1) begin
        MemRd_i = 1'b0;
        MemWr_i = 1'b0;
      end
    end
    check("ack_latency", n, LAT);
    check("stall_cycles", stalls, LAT);
    check("align_err", {31'd0, align_err_o}, {31'd0, mis});
    check("rd_data", RdData_o, exp_rd);
    MemRd_i = 1'b0;
    MemWr_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("ack_pulse", {31'd0, ack_o}, 32'd0);
    check("rd_count", {16'd0, rd_count_o}, rdc);
    check("wr_count", {16'd0, wr_count_o}, wrc);
  endtask
  initial begin
    logic [31:0] a, old20;
    rst_i = 1'b1;
    MemRd_i = 1'b0;
    MemWr_i = 1'b0;
    addr_i = '0;
    WrData_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_rdata", RdData_o, 32'd0);
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_aerr", {31'd0, align_err_o}, 32'd0);
    check("rst_rdc", {16'd0, rd_count_o}, 32'd0);
    check("rst_wrc", {16'd0, wr_count_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b1);
    op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    op(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    op(1'b0, 1'b1, 32'h102, 32'h12345678, 1'b1);
    op(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
    op(1'b0, 1'b1, 32'h400, 32'hA5, 1'b1);
    op(1'b1, 1'b0, 32'h000, 32'h0, 1'b1);
    op(1'b1, 1'b0, 32'h004, 32'h0, 1'b1);
    op(1'b1, 1'b1, 32'h8, 32'h55, 1'b1);
    op(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    op(1'b1, 1'b0, 32'hFFFF_FF03, 32'h0, 1'b1);
    old20 = mem_m[8];
    MemWr_i = 1'b1;
    addr_i = 32'h20;
    WrData_i = 32'hCAFEF00D;
    @(negedge clk_i);
    check("abort_stall_T", {31'd0, stall_o}, 32'd1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    MemWr_i = 1'b0;
    @(negedge clk_i);
    check("abort_stall_rst", {31'd0, stall_o}, 32'd0);
    check("abort_ack_rst", {31'd0, ack_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    rdc = 0;
    wrc = 0;
    exp_rd = 32'd0;
    for (int k = 0; k < LAT + 1; k++) begin
      @(negedge clk_i);
      check("abort_no_ack", {31'd0, ack_o}, 32'd0);
      check("abort_no_stall", {31'd0, stall_o}, 32'd0);
    end
    check("abort_rdc", {16'd0, rd_count_o}, 32'd0);
    check("abort_wrc", {16'd0, wr_count_o}, 32'd0);
    @(posedge clk_i);
    #1;
    op(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    check("abort_mem_kept", RdData_o, old20);
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      case ($urandom_range(0, 2))
        0: op(1'b1, 1'b0, a, $urandom, 1'($urandom_range(0, 1)));
        1: op(1'b0, 1'b1, a, $urandom, 1'($urandom_range(0, 1)));
        default: op(1'b1, 1'b1, a, $urandom, 1'($urandom_range(0, 1)));
      endcase
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
